// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands LSB first,
// publishing (minuend - subtrahend) mod 2^WIDTH and the final borrow after WIDTH steps.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] w_r_next;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

    // Full-subtractor cell on the current LSBs, and the result register after this bit enters.
    always_comb begin
        w_d      = fs_diff(r_a_sr[0], r_b_sr[0], r_borrow);
        w_bout   = fs_borrow(r_a_sr[0], r_b_sr[0], r_borrow);
        w_last   = (r_cnt == LAST_CNT);
        w_r_next = r_r_sr >> 1'b1;
        w_r_next[WIDTH-1] = w_d;
    end

    // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs; published result only moves on the last RUN bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_r_sr     <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr   <= minuend;
                        r_b_sr   <= subtrahend;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_a_sr   <= r_a_sr >> 1'b1;
                    r_b_sr   <= r_b_sr >> 1'b1;
                    r_r_sr   <= w_r_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (w_last) begin
                        difference <= w_r_next;
                        borrow_out <= w_bout;
                        done       <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 scenarios plus an exhaustive WIDTH=3 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8;
    logic       start3;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bo8;
    logic       busy3;
    logic       done3;
    logic [2:0] d3;
    logic       bo3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .minuend    (a8),
        .subtrahend (b8),
        .busy       (busy8),
        .done       (done8),
        .difference (d8),
        .borrow_out (bo8)
    );

    serial_subtractor #(.WIDTH(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .minuend    (a3),
        .subtrahend (b3),
        .busy       (busy3),
        .done       (done3),
        .difference (d3),
        .borrow_out (bo3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; operands are scrambled during RUN to show they are ignored.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_b, input string tag);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check({tag, "_busy_run"}, 64'(busy8), 64'(1'b1));
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(8));
        check({tag, "_diff"}, 64'(d8), 64'(exp_d));
        check({tag, "_borrow"}, 64'(bo8), 64'(exp_b));
        check({tag, "_busy_done"}, 64'(busy8), 64'(1'b1));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done8), 64'(1'b0));
        check({tag, "_busy_idle"}, 64'(busy8), 64'(1'b0));
        check({tag, "_diff_hold"}, 64'(d8), 64'(exp_d));
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b);
        int n;
        logic [2:0] exp_d;
        logic       exp_b;
        exp_d = 3'(a - b);
        exp_b = (a < b);
        @(negedge clk);
        a3 = a; b3 = b; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("w3_%0d_%0d_latency", a, b), 64'(n), 64'(3));
        check($sformatf("w3_%0d_%0d_diff", a, b), 64'(d3), 64'(exp_d));
        check($sformatf("w3_%0d_%0d_borrow", a, b), 64'(bo3), 64'(exp_b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dones;
        int t_first;
        int t_second;

        rst_n = 1'b0; start8 = 1'b0; start3 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; a3 = 3'd0; b3 = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'(1'b0));
        check("rst_done8", 64'(done8), 64'(1'b0));
        check("rst_diff8", 64'(d8), 64'(8'd0));
        check("rst_borrow8", 64'(bo8), 64'(1'b0));
        check("rst_busy3", 64'(busy3), 64'(1'b0));
        rst_n = 1'b1;

        op8(8'd200, 8'd55, 8'h91, 1'b0, "a200_b55");
        op8(8'd55, 8'd200, 8'h6F, 1'b1, "a55_b200");
        op8(8'hA5, 8'hA5, 8'h00, 1'b0, "equal");
        op8(8'h00, 8'h01, 8'hFF, 1'b1, "ripple");

        // Second start during RUN must be dropped; previous FF/1 result held until done.
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            if (done8 === 1'b1) begin
                dones++;
                check("b2b_diff", 64'(d8), 64'(8'd7));
                check("b2b_borrow", 64'(bo8), 64'(1'b0));
            end else if (dones == 0 && i < 6) begin
                check("b2b_hold_diff", 64'(d8), 64'(8'hFF));
                check("b2b_hold_borrow", 64'(bo8), 64'(1'b1));
            end
        end
        check("b2b_done_count", 64'(dones), 64'(1));

        // start held high: operations accepted every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'd20; b8 = 8'd5; start8 = 1'b1;
        t_first = -1; t_second = -1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
        end
        start8 = 1'b0;
        check("cont_first_done", 64'(t_first), 64'(8));
        check("cont_spacing", 64'(t_second - t_first), 64'(10));
        check("cont_diff", 64'(d8), 64'(8'd15));
        n = 0;
        while (busy8 === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cont_drain", 64'(busy8), 64'(1'b0));

        // Reset mid-operation clears everything at once; no done follows.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 64'(busy8), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'(1'b0));
        check("midrst_done", 64'(done8), 64'(1'b0));
        check("midrst_diff", 64'(d8), 64'(8'd0));
        check("midrst_borrow", 64'(bo8), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'(0));
        check("midrst_diff_after", 64'(d8), 64'(8'd0));

        // start already high when reset releases: taken on the first edge.
        @(negedge clk);
        rst_n = 1'b0; a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("rel_start_busy", 64'(busy8), 64'(1'b1));
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rel_start_latency", 64'(n), 64'(8));
        check("rel_start_diff", 64'(d8), 64'(8'd5));
        @(negedge clk);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                op3(3'(a), 3'(b));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: computes difference = minuend - subtrahend, one bit per clock, LSB first.
- Each step uses a single full-subtractor cell and a registered borrow flop.
- It is the subtract-direction counterpart of the full adder, for area-constrained datapaths that can tolerate WIDTH-cycle latency.
- A start/busy/done handshake sequences the operation; the result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- minuend  input  WIDTH  unsigned operand A; captured on the accepted start edge.
- subtrahend  input  WIDTH  unsigned operand B; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; result valid.
- difference  output  WIDTH  (A - B) mod 2^WIDTH; registered and held.
- borrow_out  output  1  final borrow; 1 iff A < B unsigned. Registered and held.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; busy=0, done=0, difference=0, borrow_out=0.
  - Shift registers, borrow flop and bit counter all cleared.
  - Reset mid-operation aborts the operation; the partial result is never published.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1 at edge k:
    - Load a_sr<=minuend, b_sr<=subtrahend.
    - Set borrow<=0, cnt<=0, busy<=1.
  - RUN, each edge processes bit cnt, using a=a_sr[0], b=b_sr[0], bin=borrow:
    - d = a ^ b ^ bin
    - bout = (~a & b) | (~(a ^ b) & bin)
    - Shift d into r_sr at the MSB end, shift a_sr and b_sr right, borrow<=bout, cnt<=cnt+1.
  - RUN -> DONE on the edge processing bit WIDTH-1 (edge k+WIDTH). On that same edge:
    - difference<=final r_sr (including this bit).
    - borrow_out<=bout; done<=1.
  - DONE -> IDLE unconditionally at edge k+WIDTH+1:
    - done<=0, busy<=0.
- Timing:
  - Latency: done is high during the cycle after edge k+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles. Earliest next accepted start is edge k+WIDTH+2.
- Handshake rules:
  - start while busy=1 (RUN or DONE) is ignored; it is not queued or remembered.
  - Operand inputs are don't-care except on the accepted start edge. Changes during RUN have no effect.
  - difference and borrow_out change only at the DONE transition or on reset. Between operations they hold the last result.
- Counter width: clog2(WIDTH+1) bits. WIDTH=1 is legal (RUN lasts exactly one cycle).
- Boundary conditions:
  - Borrow ripples across all bits (e.g. 0 - 1): wrap-around is modular; borrow_out=1.
  - Equal operands: difference=0, borrow_out=0.
  - start held high continuously: an operation starts every WIDTH+2 cycles.
  - rst_n deasserted while start=1: start is accepted on the first clock edge after release.

Test Plan:
- WIDTH=8; start with A=200, B=55 -> after 8 RUN edges done pulses for exactly one cycle; difference=145 (0x91), borrow_out=0; busy high for 9 cycles.
- A=55, B=200 -> difference=0x6F (111), borrow_out=1.
- A=0x00, B=0x01 -> difference=0xFF, borrow_out=1.
- A=0xA5, B=0xA5 -> difference=0x00, borrow_out=0.
- Back-to-back: A=10, B=3, then start pulsed again at RUN cycle 3 with A=1, B=2 -> second start ignored; only one done pulse; difference=7, borrow_out=0; prior outputs held until then.
- Reset mid-operation: start A=0xF0, B=0x0F; drop rst_n at RUN cycle 4 -> busy=0, done=0, difference=0, borrow_out=0 immediately; no done pulse follows.
- Exhaustive check at WIDTH=3 (all 64 operand pairs) against a reference model (A-B) mod 8 and A<B.
